uart_reg_loader: RTL and testbench
==================================

Name: uart_reg_loader

Overview:
Serial register-write front end for the sound core. It receives UART bytes at a parametrised baud rate and decodes data/address byte pairs into single-cycle register write strobes. Writes are addressed to NUM_CH channels with REGS_PER_CH registers each. It sits between the host `rx` pin and the channel register files in fpga_top, and adds glitch rejection, error reporting and pair timeout.

Parameters:
- CLK_HZ, 12_000_000, system clock frequency.
- BAUD, 9600, serial bit rate.
- OVERSAMPLE, 16, rx sample ticks per bit. Divisor = CLK_HZ/(BAUD*OVERSAMPLE), truncated (78 at defaults).
- NUM_CH, 4, number of addressable channels.
- REGS_PER_CH, 4, registers per channel; must be a power of 2.
- TIMEOUT_BYTES, 4, idle byte-times after which a pending data byte is discarded; 0 disables the timeout.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous, active-high reset.
- rx  in  1  asynchronous UART input, idle high.
- err_clr  in  1  single-cycle pulse; clears the sticky error flags.
- we  out  1  single-cycle register write strobe.
- waddr  out  6  flat register index (channel*REGS_PER_CH + reg).
- wdata  out  8  register write data.
- ch_sel  out  NUM_CH  one-hot channel select; valid only while we=1, otherwise 0.
- rx_valid  out  1  single-cycle pulse for each well-framed byte.
- rx_data  out  8  last received byte; held until the next byte.
- err_frame  out  1  sticky: a stop bit was sampled low.
- err_orphan  out  1  sticky: an address byte arrived with no pending data.
- err_range  out  1  sticky: decoded index >= NUM_CH*REGS_PER_CH.

Behaviour:
- Reset: all outputs are 0; the receiver returns to IDLE and the pending data byte is cleared. A reset mid-byte aborts the byte, and no rx_valid follows.
- Synchroniser: 2 flops on rx, followed by a majority-of-3 filter on oversample ticks.
- Receiver FSM, states IDLE, START, DATA, STOP:
  - IDLE -> START on a filtered falling edge; the tick counter is cleared.
  - START: at tick OVERSAMPLE/2, if the line is low go to DATA, otherwise treat it as a glitch and return to IDLE.
  - DATA: sample at mid-bit every OVERSAMPLE ticks; 8 bits, LSB first.
  - STOP: sample at mid-bit. If high, pulse rx_valid one clock later with rx_data updated. If low, set err_frame, emit no rx_valid, clear pending, and return to IDLE only once the line is high.
- Framer FSM, states EMPTY, PENDING; it acts on rx_valid.
  - Byte with bit7=0 (data byte): latch bits[6:0] and go to PENDING. A second data byte replaces the first (latest wins).
  - Byte with bit7=1 (address byte) while in PENDING:
    - index = byte[6:1], wdata = {byte[0], pending[6:0]}.
    - If index is in range: on the clock after rx_valid, drive we=1 with waddr=index, wdata, and ch_sel = one-hot(index / REGS_PER_CH).
    - If index is out of range: no strobe; set err_range.
    - Either way, return to EMPTY.
  - Address byte while in EMPTY: set err_orphan; no strobe.
- Timeout: in PENDING, count byte-times (10*OVERSAMPLE ticks) during which the receiver is in IDLE. When the count reaches TIMEOUT_BYTES, go to EMPTY silently. The count resets on any start bit.
- Latency: we follows the rx_valid of the address byte by exactly 1 clock. we is never asserted on two consecutive clocks.
- Error flags:
  - Each flag is set on its event and held.
  - err_clr clears all three flags.
  - If err_clr coincides with a set event, the set wins.

Decomposition:
- Package `uart_pkg`:
  - Divisor computation function.
  - Receiver and framer state enums.
  - Constants ADDR_FLAG_BIT=7 and INDEX_W=6.
- Sub-module `uart_rx`: synchroniser, filter, receiver FSM; outputs rx_valid, rx_data, frame_err.
- The framer, timeout logic and error flags stay in uart_reg_loader.

Test Plan:
- At defaults, send 0x27 then 0x83 (bytes are driven at 1248 clk/bit) -> one we pulse with waddr=1, wdata=0xA7, ch_sel=4'b0001; no error flags set.
- Send 0x30,0x88, then 0x40,0x91 -> first pulse waddr=4, wdata=0x30, ch_sel=4'b0010; second pulse waddr=8, wdata=0xC0, ch_sel=4'b0100.
- Send 0x83 alone -> no we; err_orphan=1. Then pulse err_clr -> err_orphan=0.
- Send 0x27, then a byte with a low stop bit, then 0x84 -> err_frame=1, pending is cleared, 0x84 sets err_orphan, no we.
- Send 0x05 then 0xA0 (index 16 with NUM_CH=4) -> no we; err_range=1. Separately, send 0x05, stay idle for 5 byte-times, then send 0x84 -> err_orphan=1 (timeout expired).
- Pull rx low for 3 clocks -> no rx_valid. Assert rst mid-byte, then send 0x27,0x83 -> exactly one correct write.

Source files
------------

// File: rtl/uart_pkg.sv
// uart_pkg: shared constants, state types and baud divisor helper for the UART register loader
package uart_pkg;
   localparam int ADDR_FLAG_BIT = 7;
   localparam int INDEX_W = 6;
   typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;
   typedef enum logic {FR_EMPTY, FR_PENDING} fr_state_t;
   function automatic int baud_div(input int clk_hz, input int baud, input int oversample);
      return clk_hz / (baud * oversample);
   endfunction
endpackage

// File: rtl/uart_rx.sv
// uart_rx: oversampling UART byte receiver with synchroniser, majority filter and framing check
module uart_rx import uart_pkg::*; #(
   parameter int CLK_HZ = 12_000_000,
   parameter int BAUD = 9600,
   parameter int OVERSAMPLE = 16
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       rx,
   output logic       rx_valid,
   output logic [7:0] rx_data,
   output logic       frame_err,
   output logic       tick,
   output logic       rx_idle
);
   localparam int DIV = baud_div(CLK_HZ, BAUD, OVERSAMPLE);
   localparam int DW = $clog2(DIV + 1);
   localparam int OW = $clog2(OVERSAMPLE + 1);
   logic [DW-1:0] dcnt;
   logic [1:0] sync;
   logic [2:0] hist;
   logic line;
   rx_state_t st, st_n;
   logic [OW-1:0] tcnt, tcnt_n;
   logic [2:0] bcnt, bcnt_n;
   logic [7:0] shreg, shreg_n;
   logic brk, brk_n, valid_n, ferr_n;
   assign tick = dcnt == DW'(DIV - 1);
   assign line = (hist[0] & hist[1]) | (hist[0] & hist[2]) | (hist[1] & hist[2]);
   assign rx_idle = st == RX_IDLE;
   // oversample tick divider
   always_ff @(posedge clk)
      dcnt <= (rst || tick) ? '0 : dcnt + 1'b1;
   // two-flop synchroniser feeding a three-sample history for the majority vote
   always_ff @(posedge clk) begin
      if (rst) begin
         sync <= 2'b11;
         hist <= 3'b111;
      end else begin
         sync <= {sync[0], rx};
         if (tick) hist <= {hist[1:0], sync[1]};
      end
   end
   // receiver next state: start qualification, mid-bit sampling, stop check and break wait
   always_comb begin
      st_n = st;
      tcnt_n = tcnt;
      bcnt_n = bcnt;
      shreg_n = shreg;
      brk_n = brk;
      valid_n = 1'b0;
      ferr_n = 1'b0;
      if (tick) begin
         case (st)
            RX_IDLE: if (!line) begin
               st_n = RX_START;
               tcnt_n = '0;
            end
            RX_START: if (tcnt == OW'(OVERSAMPLE / 2 - 1)) begin
               st_n = line ? RX_IDLE : RX_DATA;
               tcnt_n = '0;
               bcnt_n = '0;
            end else tcnt_n = tcnt + 1'b1;
            RX_DATA: if (tcnt == OW'(OVERSAMPLE - 1)) begin
               tcnt_n = '0;
               shreg_n = {line, shreg[7:1]};
               bcnt_n = bcnt + 1'b1;
               st_n = bcnt == 3'd7 ? RX_STOP : RX_DATA;
            end else tcnt_n = tcnt + 1'b1;
            RX_STOP: if (brk) begin
               st_n = line ? RX_IDLE : RX_STOP;
               brk_n = !line;
            end else if (tcnt == OW'(OVERSAMPLE - 1)) begin
               tcnt_n = '0;
               valid_n = line;
               ferr_n = !line;
               brk_n = !line;
               st_n = line ? RX_IDLE : RX_STOP;
            end else tcnt_n = tcnt + 1'b1;
         endcase
      end
   end
   // receiver state and output registers; the byte is presented one clock after the stop sample
   always_ff @(posedge clk) begin
      if (rst) begin
         st <= RX_IDLE;
         tcnt <= '0;
         bcnt <= '0;
         shreg <= '0;
         brk <= 1'b0;
         rx_valid <= 1'b0;
         frame_err <= 1'b0;
         rx_data <= '0;
      end else begin
         st <= st_n;
         tcnt <= tcnt_n;
         bcnt <= bcnt_n;
         shreg <= shreg_n;
         brk <= brk_n;
         rx_valid <= valid_n;
         frame_err <= ferr_n;
         if (valid_n) rx_data <= shreg;
      end
   end
endmodule

// File: rtl/uart_reg_loader.sv
// uart_reg_loader: decodes UART data/address byte pairs into channel register write strobes
module uart_reg_loader import uart_pkg::*; #(
   parameter int CLK_HZ = 12_000_000,
   parameter int BAUD = 9600,
   parameter int OVERSAMPLE = 16,
   parameter int NUM_CH = 4,
   parameter int REGS_PER_CH = 4,
   parameter int TIMEOUT_BYTES = 4
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               rx,
   input  logic               err_clr,
   output logic               we,
   output logic [INDEX_W-1:0] waddr,
   output logic [7:0]         wdata,
   output logic [NUM_CH-1:0]  ch_sel,
   output logic               rx_valid,
   output logic [7:0]         rx_data,
   output logic               err_frame,
   output logic               err_orphan,
   output logic               err_range
);
   localparam logic [6:0] NREG = 7'(NUM_CH * REGS_PER_CH);
   localparam int RSH = $clog2(REGS_PER_CH);
   localparam logic [15:0] BT_LAST = 16'(10 * OVERSAMPLE - 1);
   localparam logic [15:0] TOB = 16'(TIMEOUT_BYTES);
   logic frame_err, tick, rx_idle;
   logic [INDEX_W-1:0] idx;
   logic is_addr, in_range, timed_out, do_wr, set_orphan, set_range;
   fr_state_t st, st_n;
   logic [6:0] pend;
   logic [15:0] tk, nb;
   uart_rx #(.CLK_HZ(CLK_HZ), .BAUD(BAUD), .OVERSAMPLE(OVERSAMPLE)) u_rx (
      .clk(clk), .rst(rst), .rx(rx), .rx_valid(rx_valid), .rx_data(rx_data),
      .frame_err(frame_err), .tick(tick), .rx_idle(rx_idle)
   );
   assign idx = rx_data[6:1];
   assign is_addr = rx_data[ADDR_FLAG_BIT];
   assign in_range = {1'b0, idx} < NREG;
   assign timed_out = TIMEOUT_BYTES != 0 && st == FR_PENDING && nb == TOB;
   assign do_wr = rx_valid && is_addr && st == FR_PENDING && in_range;
   assign set_orphan = rx_valid && is_addr && st == FR_EMPTY;
   assign set_range = rx_valid && is_addr && st == FR_PENDING && !in_range;
   // framer next state: a framing error or timeout drops the pending byte
   always_comb begin
      st_n = st;
      if (frame_err) st_n = FR_EMPTY;
      else if (rx_valid) st_n = is_addr ? FR_EMPTY : FR_PENDING;
      else if (timed_out) st_n = FR_EMPTY;
   end
   // framer state register
   always_ff @(posedge clk)
      st <= rst ? FR_EMPTY : st_n;
   // idle byte-time counter, restarted by any start bit or when nothing is pending
   always_ff @(posedge clk) begin
      if (rst || st != FR_PENDING || !rx_idle) begin
         tk <= '0;
         nb <= '0;
      end else if (tick) begin
         tk <= tk == BT_LAST ? '0 : tk + 1'b1;
         if (tk == BT_LAST) nb <= nb + 1'b1;
      end
   end
   // pending data latch, write strobe outputs and sticky error flags (set beats clear)
   always_ff @(posedge clk) begin
      if (rst) begin
         pend <= '0;
         we <= 1'b0;
         waddr <= '0;
         wdata <= '0;
         ch_sel <= '0;
         err_frame <= 1'b0;
         err_orphan <= 1'b0;
         err_range <= 1'b0;
      end else begin
         if (rx_valid && !is_addr) pend <= rx_data[6:0];
         we <= do_wr;
         if (do_wr) waddr <= idx;
         if (do_wr) wdata <= {rx_data[0], pend};
         ch_sel <= do_wr ? NUM_CH'(1) << (idx >> RSH) : '0;
         err_frame <= frame_err | (err_frame & !err_clr);
         err_orphan <= set_orphan | (err_orphan & !err_clr);
         err_range <= set_range | (err_range & !err_clr);
      end
   end
endmodule

// File: tb/tb_uart_reg_loader.sv
// tb_uart_reg_loader: scoreboard bench driving serial bytes against a pair-decoding reference model
module tb_uart_reg_loader;
   localparam int CLK_HZ = 12_000_000;
   localparam int BAUD = 192_000;
   localparam int OS = 16;
   localparam int NCH = 4;
   localparam int RPC = 4;
   localparam int TOB = 4;
   localparam int BIT = (CLK_HZ / (BAUD * OS)) * OS;
   localparam int BYTE_T = 10 * BIT;
   logic clk = 0, rst = 1, rx = 1, err_clr = 0;
   logic we, rx_valid, err_frame, err_orphan, err_range;
   logic [5:0] waddr;
   logic [7:0] wdata, rx_data;
   logic [NCH-1:0] ch_sel;
   int n_chk = 0, n_fail = 0, n_rxv = 0, n_wr = 0, m_wr = 0, pend = -1;
   logic m_frame = 0, m_orphan = 0, m_range = 0, we_q = 0;
   logic [17:0] exp_wr[$];
   logic [7:0] exp_rx[$];
   logic [17:0] e;

   uart_reg_loader #(.CLK_HZ(CLK_HZ), .BAUD(BAUD), .OVERSAMPLE(OS), .NUM_CH(NCH),
      .REGS_PER_CH(RPC), .TIMEOUT_BYTES(TOB)) dut (
      .clk(clk), .rst(rst), .rx(rx), .err_clr(err_clr), .we(we), .waddr(waddr),
      .wdata(wdata), .ch_sel(ch_sel), .rx_valid(rx_valid), .rx_data(rx_data),
      .err_frame(err_frame), .err_orphan(err_orphan), .err_range(err_range)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic model_byte(input logic [7:0] b, input bit good);
      logic [5:0] idx;
      if (!good) begin
         m_frame = 1;
         pend = -1;
         return;
      end
      exp_rx.push_back(b);
      if (!b[7]) pend = int'(b[6:0]);
      else if (pend < 0) m_orphan = 1;
      else begin
         idx = b[6:1];
         if (idx < NCH * RPC) begin
            exp_wr.push_back({4'(1 << (idx / RPC)), idx, b[0], 7'(pend)});
            m_wr++;
         end else m_range = 1;
         pend = -1;
      end
   endtask

   task automatic send(input logic [7:0] b, input bit good = 1);
      model_byte(b, good);
      rx = 0;
      repeat (BIT) @(negedge clk);
      for (int i = 0; i < 8; i++) begin
         rx = b[i];
         repeat (BIT) @(negedge clk);
      end
      rx = good;
      repeat (BIT) @(negedge clk);
      rx = 1;
      repeat (good ? 4 : BIT) @(negedge clk);
   endtask

   task automatic idle(input int n);
      repeat (n * BYTE_T) @(negedge clk);
      if (TOB != 0 && n >= TOB) pend = -1;
   endtask

   task automatic clear();
      err_clr = 1;
      @(negedge clk);
      err_clr = 0;
      m_frame = 0;
      m_orphan = 0;
      m_range = 0;
      @(negedge clk);
   endtask

   task automatic check_flags(input string tag);
      chk({tag, "_err_frame"}, err_frame, m_frame);
      chk({tag, "_err_orphan"}, err_orphan, m_orphan);
      chk({tag, "_err_range"}, err_range, m_range);
      chk({tag, "_writes"}, n_wr, m_wr);
   endtask

   always @(negedge clk) begin
      if (rst) we_q = 0;
      else begin
         if (rx_valid) begin
            n_rxv++;
            if (exp_rx.size() == 0) begin
               n_chk++;
               n_fail++;
               $display("FAIL rx_unexpected: got byte 0x%0h, expected none", rx_data);
            end else chk("rx_data", rx_data, exp_rx.pop_front());
         end
         if (we) begin
            n_wr++;
            chk("we_gap", we_q, 0);
            if (exp_wr.size() == 0) begin
               n_chk++;
               n_fail++;
               $display("FAIL we_unexpected: got waddr 0x%0h wdata 0x%0h, expected no write", waddr, wdata);
            end else begin
               e = exp_wr.pop_front();
               chk("waddr", waddr, e[13:8]);
               chk("wdata", wdata, e[7:0]);
               chk("ch_sel", ch_sel, e[17:14]);
            end
         end else chk("ch_sel_idle", ch_sel, 0);
         we_q = we;
      end
   end

   initial begin
      repeat (200_000) @(posedge clk);
      $display("FAIL watchdog: cycle budget exceeded");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [7:0] b;
      repeat (3) @(negedge clk);
      chk("rst_we", we, 0);
      chk("rst_waddr", waddr, 0);
      chk("rst_wdata", wdata, 0);
      chk("rst_ch_sel", ch_sel, 0);
      chk("rst_rx_valid", rx_valid, 0);
      chk("rst_rx_data", rx_data, 0);
      check_flags("rst");
      rst = 0;
      repeat (2 * BIT) @(negedge clk);
      send(8'h27); send(8'h83);
      check_flags("pair1");
      send(8'h30); send(8'h88); send(8'h40); send(8'h91);
      check_flags("pair2");
      send(8'h83);
      check_flags("orphan");
      clear();
      check_flags("orphan_clr");
      send(8'h27); send(8'h55, 0); send(8'h84);
      check_flags("frame");
      clear();
      send(8'h05); send(8'hA0);
      check_flags("range");
      clear();
      send(8'h05); idle(5); send(8'h84);
      check_flags("timeout");
      clear();
      send(8'h05); idle(3); send(8'h84);
      check_flags("no_timeout");
      b = 8'(n_rxv);
      rx = 0;
      repeat (3) @(negedge clk);
      rx = 1;
      repeat (12 * BIT) @(negedge clk);
      chk("glitch_rxv", n_rxv, int'(b));
      send(8'h83); send(8'h11);
      rx = 0;
      repeat (3 * BIT) @(negedge clk);
      rst = 1;
      repeat (3) @(negedge clk);
      rx = 1;
      chk("rst_mid_wdata", wdata, 0);
      rst = 0;
      pend = -1;
      m_frame = 0; m_orphan = 0; m_range = 0;
      check_flags("rst_mid");
      repeat (2 * BIT) @(negedge clk);
      send(8'h85);
      check_flags("rst_pend");
      clear();
      send(8'h27); send(8'h83);
      check_flags("rst_pair");
      for (int k = 0; k < 16; k++) begin
         b = $urandom_range(0, 1) ? {1'b1, 6'($urandom_range(0, 17)), 1'($urandom)} : {1'b0, 7'($urandom)};
         send(b);
         repeat ($urandom_range(0, 100)) @(negedge clk);
         if ($urandom_range(0, 3) == 0) clear();
         check_flags("rnd");
      end
      repeat (20) @(negedge clk);
      chk("wr_queue_left", exp_wr.size(), 0);
      chk("rx_queue_left", exp_rx.size(), 0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
